// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and width helper for the done-event round counter
package counter_pkg;

    localparam int COUNTER_TARGET_DEFAULT = 7;

    // Bits needed to hold values 0..target.
    function automatic int cnt_w(input int target);
        return $clog2(target + 1);
    endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - counts done events and flags each completed round of TARGET events
// Optional debug outputs (dbg_count, dbg_rounds) are enabled by defining COUNTER_DEBUG_EN.
module counter
    import counter_pkg::*;
#(
    parameter int TARGET = COUNTER_TARGET_DEFAULT,
    localparam int CNT_W = cnt_w(TARGET)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done,
`ifdef COUNTER_DEBUG_EN
    output logic [CNT_W-1:0] dbg_count,
    output logic [7:0]       dbg_rounds,
`endif
    output logic             en_y
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TARGET - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_en_y;
    logic             w_last;

    // Out-of-range counts collapse onto the final slot so the next done wraps cleanly.
    assign w_last = (r_count >= LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_en_y  <= 1'b0;
        end else if (done) begin
            if (w_last) begin
                r_count <= '0;
                r_en_y  <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                r_en_y  <= 1'b0;
            end
        end
    end

    assign en_y = r_en_y;

`ifdef COUNTER_DEBUG_EN
    logic [7:0] r_rounds;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rounds <= '0;
        end else if (done && w_last) begin
            r_rounds <= r_rounds + 8'd1;
        end
    end

    assign dbg_count  = r_count;
    assign dbg_rounds = r_rounds;
`endif

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - scoreboard bench for counter against an event-total reference model
module tb_counter;
    import counter_pkg::*;

    localparam int T  = COUNTER_TARGET_DEFAULT;
    localparam int CW = cnt_w(T);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done = 1'b0;
    logic en_y;
`ifdef COUNTER_DEBUG_EN
    logic [CW-1:0] dbg_count;
    logic [7:0]    dbg_rounds;
`endif

    counter #(.TARGET(T)) dut (
        .clk   (clk),
        .reset (reset),
        .done  (done),
`ifdef COUNTER_DEBUG_EN
        .dbg_count  (dbg_count),
        .dbg_rounds (dbg_rounds),
`endif
        .en_y  (en_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit en;
        int cnt;
        int rounds;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   total = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: everything follows from the number of done events since reset.
    task automatic push_exp();
        exp_t e;
        e.due    = cyc + 1;
        e.en     = (total > 0) && (total % T == 0);
        e.cnt    = total % T;
        e.rounds = (total / T) % 256;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("en_y", int'(en_y), int'(e.en));
`ifdef COUNTER_DEBUG_EN
            chk("dbg_count", int'(dbg_count), e.cnt);
            chk("dbg_rounds", int'(dbg_rounds), e.rounds);
`endif
        end
    end

    task automatic cycle(input bit d);
        @(posedge clk);
        #1;
        done = d;
        if (d) total++;
        push_exp();
    endtask

    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1);
            for (int g = 0; g < gap; g++) cycle(1'b0);
        end
    endtask

    // Reset lands mid-cycle, away from any edge; outputs must clear without a clock.
    task automatic do_reset(input int hold);
        @(posedge clk);
        @(negedge clk);
        #1;
        done = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_en_y", int'(en_y), 0);
`ifdef COUNTER_DEBUG_EN
        chk("async_reset_count", int'(dbg_count), 0);
        chk("async_reset_rounds", int'(dbg_rounds), 0);
`endif
        total = 0;
        repeat (hold) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_en_y", int'(en_y), 0);
`ifdef COUNTER_DEBUG_EN
        chk("reset_count", int'(dbg_count), 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        pulses(7, 0);
        pulses(2, 0);
        cycle(1'b0);
        pulses(7, 1);

        do_reset(2);
        pulses(6, 0);
        cycle(1'b0);
        pulses(2, 0);

        pulses(6, 1);
        do_reset(1);

        pulses(4, 1);
        do_reset(3);
        pulses(7, 1);
        cycle(1'b0);

        do_reset(1);
        pulses(21, 0);
        cycle(1'b0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset($urandom_range(1, 3));
            else cycle($urandom_range(0, 2) != 0);
        end
        cycle(1'b0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) chk("scoreboard_drained", q.size(), 0);
        else chk("scoreboard_drained", 0, 0 * q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
